// File: rtl/gfx_defs.sv
// Shared graphics types and constants for the scanout/scanin paths.
// Resolution defaults to 4x2; a build may predefine the GFX_X_RES and
// GFX_Y_RES macros to select another size.
`ifndef GFX_X_RES
`define GFX_X_RES 4
`endif
`ifndef GFX_Y_RES
`define GFX_Y_RES 2
`endif

package gfx_defs;

    localparam int unsigned GFX_X_RES = `GFX_X_RES;
    localparam int unsigned GFX_Y_RES = `GFX_Y_RES;
    localparam int unsigned GFX_NPIX  = GFX_X_RES * GFX_Y_RES;
    localparam int unsigned LIN_W     = (GFX_NPIX > 1) ? $clog2(GFX_NPIX) : 1;

    typedef logic [LIN_W-1:0] linear_coord;
    typedef logic [LIN_W:0]   half_coord;
    typedef logic [15:0]      mem_word;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb30;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24;

    // Linear index of the final pixel of a frame
    localparam linear_coord GFX_LAST_IDX = linear_coord'(GFX_NPIX - 1);

    // Scan-in framing state
    typedef enum logic {
        SYNC,
        CAPTURE
    } scanin_state_e;

endpackage

// File: rtl/gfx_scanin_pack.sv
// rgb30 -> rgb24 channel conversion for the scan-in path.
// Define GFX_SCANIN_ROUND_EN for round-to-nearest (saturating at 255);
// otherwise channels are truncated to their top 8 bits.
module gfx_scanin_pack
    import gfx_defs::*;
(
    input  rgb30 wide,
    output rgb24 narrow
);

    function automatic logic [7:0] conv(input logic [9:0] c);
`ifdef GFX_SCANIN_ROUND_EN
        logic [10:0] s;
        s = {1'b0, c} + 11'd2;
        return s[10] ? 8'hFF : s[9:2];
`else
        return c[9:2];
`endif
    endfunction

    assign narrow.r = conv(wide.r);
    assign narrow.g = conv(wide.g);
    assign narrow.b = conv(wide.b);

endmodule

// File: rtl/gfx_scanin.sv
// Video capture: rgb30 Avalon-ST frames into the framebuffer through an
// Avalon-MM write master, one pixel as two consecutive mem_word halves.
// Conversion rounding is selected by GFX_SCANIN_ROUND_EN (see gfx_scanin_pack).
module gfx_scanin
    import gfx_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  rgb30        in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic        fb_waitrequest,
    output logic        fb_write,
    output half_coord   fb_address,
    output mem_word     fb_writedata,
    output logic        frame_done,
    output logic        frame_error
);

    scanin_state_e state, state_nxt;

    rgb24        pix_cv;
    rgb24        pix_q;
    linear_coord idx_q, idx_nxt;
    logic        full_q, phase_q;
    logic        done_flag_q;
    logic        err_q;

    logic        wr_acc, beat_acc, load;
    logic        beat_err, beat_done;

    gfx_scanin_pack u_pack (
        .wide   (in_data),
        .narrow (pix_cv)
    );

    assign wr_acc   = full_q && !fb_waitrequest;
    // Ready as the high half completes so a new beat loads with no bubble
    assign in_ready = !full_q || (phase_q && !fb_waitrequest);
    assign beat_acc = in_valid && in_ready;
    // In SYNC only a start-of-packet beat is kept; others are consumed and dropped
    assign load     = beat_acc && (state == CAPTURE || in_startofpacket);

    // Framing state register
    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else     state <= state_nxt;
    end

    // Next state, index of the loaded beat and framing verdict for it
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        beat_err  = 1'b0;
        beat_done = 1'b0;
        if (load) begin
            if (in_startofpacket) begin
                idx_nxt  = '0;
                beat_err = (state == CAPTURE);
            end else begin
                idx_nxt  = idx_q + linear_coord'(1);
            end
            if (in_endofpacket && idx_nxt == GFX_LAST_IDX) begin
                beat_done = 1'b1;
                state_nxt = SYNC;
            end else if (in_endofpacket || idx_nxt == GFX_LAST_IDX) begin
                beat_err  = 1'b1;
                state_nxt = SYNC;
            end else begin
                state_nxt = CAPTURE;
            end
        end
    end

    // Holding register: load a beat, then step low half -> high half -> empty
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q       <= '0;
            idx_q       <= '0;
            full_q      <= 1'b0;
            phase_q     <= 1'b0;
            done_flag_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= load && beat_err;
            if (load) begin
                pix_q       <= pix_cv;
                idx_q       <= idx_nxt;
                full_q      <= 1'b1;
                phase_q     <= 1'b0;
                done_flag_q <= beat_done;
            end else if (wr_acc) begin
                if (!phase_q) begin
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    full_q  <= 1'b0;
                end
            end
        end
    end

    assign fb_write     = full_q;
    assign fb_address   = {idx_q, phase_q};
    assign fb_writedata = phase_q ? {8'h00, pix_q.r} : {pix_q.g, pix_q.b};
    assign frame_done   = wr_acc && phase_q && done_flag_q;
    assign frame_error  = err_q;

endmodule
